// File: rtl/sevenseg_pkg.sv
// Shared types and segment codes for the seven-segment scan controller.
// Segment bit order is {g,f,e,d,c,b,a}; dp is carried separately.
package sevenseg_pkg;

  typedef enum logic {
    BLANK,
    DRIVE
  } state_t;

  localparam logic [7:0] SEG_OFF = 8'h00;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  function automatic logic [6:0] hex2seg(
    input logic [3:0] h
  );
    logic [6:0] s;
    unique case (h)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sevenseg_scan_ctrl_seg_decode.sv
// Combinational {dp,hex} to segment pattern decoder.
// blank forces g..a off while dp still passes through.
module seg_decode
  import sevenseg_pkg::*;
(
  input  logic       dp,
  input  logic [3:0] hex,
  input  logic       blank,
  output logic [7:0] seg
);

  // pick the glyph unless this digit is a suppressed leading zero
  always_comb begin
    seg = {dp, blank ? 7'h00 : hex2seg(hex)};
  end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with blanking gap.
// Define SEVENSEG_LEADING_ZERO_BLANK_EN to suppress leading zeros.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter  int DIGITS = 4,
  parameter  int DIV    = 4096,
  localparam int AW     = $clog2(DIGITS),
  localparam int PW     = $clog2(DIV)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [4:0]        wr_data,
  output logic [7:0]        out,
  output logic [DIGITS-1:0] an,
  output logic              frame_tick
);

  localparam logic [PW-1:0] CNT_MAX = PW'(DIV - 1);
  localparam logic [DIGITS-1:0] ONE =
    {{(DIGITS-1){1'b0}}, 1'b1};

  logic [4:0]    regs [DIGITS];
  state_t        state;
  logic [AW-1:0] idx;
  logic [PW-1:0] cnt;
  logic [4:0]    cur;
  logic          lz;
  logic [7:0]    dec;

  assign cur = regs[idx];

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
  // blank when this digit and all above it hold hex 0
  always_comb begin
    lz = (idx != '0);
    for (int i = 0; i < DIGITS; i++) begin
      if (i >= int'(idx) && regs[i][3:0] != 4'h0)
        lz = 1'b0;
    end
  end
`else
  assign lz = 1'b0;
`endif

  seg_decode u_dec (
    .dp   (cur[4]),
    .hex  (cur[3:0]),
    .blank(lz),
    .seg  (dec)
  );

  // host-written digit register file
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DIGITS; i++)
        regs[i] <= '0;
    end else if (wr_en && int'(wr_addr) < DIGITS) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // scan FSM with registered segment/anode outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BLANK;
      idx        <= '0;
      cnt        <= '0;
      out        <= SEG_OFF;
      an         <= '1;
      frame_tick <= 1'b0;
    end else if (!en) begin
      out        <= SEG_OFF;
      an         <= '1;
      frame_tick <= 1'b0;
    end else begin
      unique case (state)
        BLANK: begin
          out        <= SEG_OFF;
          an         <= '1;
          frame_tick <= 1'b0;
          state      <= DRIVE;
        end
        DRIVE: begin
          out <= dec;
          an  <= ~(ONE << idx);
          if (cnt == CNT_MAX) begin
            cnt        <= '0;
            state      <= BLANK;
            frame_tick <= (int'(idx) == DIGITS - 1);
            if (int'(idx) == DIGITS - 1)
              idx <= '0;
            else
              idx <= idx + 1'b1;
          end else begin
            cnt        <= cnt + 1'b1;
            frame_tick <= 1'b0;
          end
        end
        default: state <= BLANK;
      endcase
    end
  end

endmodule
